// File: rtl/sound_pkg.sv
// sound_pkg: shared state encoding, sound-type codes and default timing constants
// for the sound event controller.
package sound_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Codes double as bit indices into the pending and enable vectors.
    typedef enum logic [1:0] {
        BOUNCE = 2'd0,
        BRICK  = 2'd1,
        LOSE   = 2'd2
    } snd_t;

    localparam int unsigned DEF_DUR_BOUNCE = 2000000;
    localparam int unsigned DEF_DUR_BRICK  = 1500000;
    localparam int unsigned DEF_DUR_LOSE   = 5000000;
    localparam int unsigned DEF_GAP        = 100000;

    function automatic logic [2:0] en_of(snd_t s);
        return 3'b001 << s;
    endfunction

endpackage

// File: rtl/sound_edge_det.sv
// sound_edge_det: registers a level and flags its rising edge.
// Ports:
//   clk10 - clock
//   rst   - asynchronous active-high reset (clears the history register)
//   level - level input, synchronous to clk10
//   pulse - high for one cycle when level is high and was low last cycle
module sound_edge_det (
    input  logic clk10,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk10 or posedge rst)
        if (rst) prev <= 1'b0;
        else     prev <= level;

    assign pulse = level & ~prev;

endmodule

// File: rtl/sound_event_ctrl.sv
// sound_event_ctrl: turns game event levels into prioritised, timed sound enables.
// Ports:
//   clk10                - clock
//   rst                  - asynchronous active-high reset
//   ev_bounce/brick/lose - event levels, synchronous to clk10
//   Sound_EN1/2/3        - registered enables for bounce/brick/lose tone generators
//   busy                 - registered, high while playing or in the silence gap
module sound_event_ctrl
    import sound_pkg::*;
#(
    parameter int unsigned DUR_BOUNCE = DEF_DUR_BOUNCE,
    parameter int unsigned DUR_BRICK  = DEF_DUR_BRICK,
    parameter int unsigned DUR_LOSE   = DEF_DUR_LOSE,
    parameter int unsigned GAP        = DEF_GAP
) (
    input  logic clk10,
    input  logic rst,
    input  logic ev_bounce,
    input  logic ev_brick,
    input  logic ev_lose,
    output logic Sound_EN1,
    output logic Sound_EN2,
    output logic Sound_EN3,
    output logic busy
);

    logic [2:0]  ev_edge;
    logic [2:0]  pend;
    logic [2:0]  clr;
    logic [2:0]  en;
    logic [23:0] cnt;
    logic [23:0] load;
    logic        preempt;
    logic        take;
    state_t      state;
    snd_t        cur;
    snd_t        sel;

    sound_edge_det u_det_bounce (.clk10(clk10), .rst(rst), .level(ev_bounce), .pulse(ev_edge[BOUNCE]));
    sound_edge_det u_det_brick  (.clk10(clk10), .rst(rst), .level(ev_brick),  .pulse(ev_edge[BRICK]));
    sound_edge_det u_det_lose   (.clk10(clk10), .rst(rst), .level(ev_lose),   .pulse(ev_edge[LOSE]));

    // Preemption works off the registered pending bit, so a lose edge aborts
    // a lower-priority sound one cycle after it is detected.
    always_comb begin
        sel     = pend[LOSE] ? LOSE : pend[BRICK] ? BRICK : BOUNCE;
        load    = sel == LOSE  ? 24'(DUR_LOSE - 1)
                : sel == BRICK ? 24'(DUR_BRICK - 1)
                :                24'(DUR_BOUNCE - 1);
        preempt = state == ST_PLAY && cur != LOSE && pend[LOSE];
        take    = (state == ST_IDLE && |pend) || preempt;
        clr     = take ? en_of(sel) : 3'b000;
    end

    always_ff @(posedge clk10 or posedge rst)
        if (rst) begin
            state <= ST_IDLE;
            cur   <= BOUNCE;
            cnt   <= '0;
            pend  <= '0;
            en    <= '0;
            busy  <= 1'b0;
        end else begin
            // A new edge on a bit being cleared this cycle keeps it pending.
            pend <= (pend & ~clr) | ev_edge;
            if (take) begin
                state <= ST_PLAY;
                cur   <= sel;
                cnt   <= load;
                en    <= en_of(sel);
                busy  <= 1'b1;
            end else if (state == ST_PLAY) begin
                if (cnt == '0) begin
                    state <= ST_GAP;
                    cnt   <= 24'(GAP - 1);
                    en    <= '0;
                end else begin
                    cnt <= cnt - 24'd1;
                end
            end else if (state == ST_GAP) begin
                if (cnt == '0) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end else begin
                    cnt <= cnt - 24'd1;
                end
            end
        end

    assign Sound_EN1 = en[BOUNCE];
    assign Sound_EN2 = en[BRICK];
    assign Sound_EN3 = en[LOSE];

endmodule

// File: doc/sound_event_ctrl.md
SOUND_EVENT_CTRL -- requirements
Module: sound_event_ctrl

Interface
REQ-001 Parameter DUR_BOUNCE, default 2000000, Sound_EN1 on-time in clk10 cycles (200 ms at 10 MHz).
REQ-002 Parameter DUR_BRICK, default 1500000, Sound_EN2 on-time in cycles.
REQ-003 Parameter DUR_LOSE, default 5000000, Sound_EN3 on-time in cycles.
REQ-004 Parameter GAP, default 100000, forced silence after each sound, in cycles; all four parameters SHALL be 1..2^24-1.
REQ-005 clk10  input  1  the single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 ev_bounce  input  1  paddle/wall collision level from game logic, synchronous to clk10.
REQ-008 ev_brick  input  1  brick-hit level, synchronous to clk10.
REQ-009 ev_lose  input  1  ball-lost level, synchronous to clk10.
REQ-010 Sound_EN1  output  1  enable to the bounce tone generator.
REQ-011 Sound_EN2  output  1  enable to the brick tone generator.
REQ-012 Sound_EN3  output  1  enable to the lose tone generator.
REQ-013 busy  output  1  high in PLAY or GAP.

Function
REQ-014 Each ev_* input SHALL be rising-edge detected against its value registered on the previous cycle; a held-high level produces exactly one event.
REQ-015 A detected edge SHALL set that type's pending bit (3-bit pending register, one bit per type, 1-deep; further edges while pending are merged).
REQ-016 FSM states SHALL be IDLE, PLAY, GAP.
REQ-017 IDLE: if any pending bit set, select highest priority (lose > brick > bounce), clear its pending bit, load counter with DUR-1 of that type, go to PLAY; else stay.
REQ-018 PLAY: exactly one Sound_EN of the selected type SHALL be high; counter decrements each cycle; at counter==0 go to GAP with counter loaded GAP-1.
REQ-019 GAP: all Sound_EN low; counter decrements; at counter==0 go to IDLE.
REQ-020 Preemption: a lose edge detected while PLAY serves bounce or brick SHALL abort it, enter PLAY for lose directly on the next cycle with counter DUR_LOSE-1; aborted sound is not resumed.
REQ-021 A lose edge during PLAY of lose or during GAP SHALL only set pending.
REQ-022 Same-cycle edge and clear of one pending bit: set wins (bit stays 1).
REQ-023 Latency: input first sampled high at edge k with FSM idle and nothing pending -> Sound_EN high from edge k+2 for exactly DUR cycles.
REQ-024 Back-to-back sounds SHALL be separated by exactly GAP+1 low cycles (GAP plus one IDLE select cycle).
REQ-025 All outputs SHALL be registered; Sound_EN1..3 one-hot or all zero at every cycle.
REQ-026 Counter SHALL be 24 bits unsigned; no wrap, loaded only from parameters.

Reset
REQ-027 rst high SHALL immediately force state IDLE, counter 0, pending 000, edge registers 0, Sound_EN1..3 0, busy 0.
REQ-028 Reset mid-PLAY SHALL cut the sound at once; events held high through reset release SHALL produce an edge on the first cycle after release (edge register reset to 0).

Structure
REQ-029 Shared package sound_pkg SHALL hold the state encoding, sound-type codes (BOUNCE, BRICK, LOSE), and the default duration/gap constants.
REQ-030 One sub-module sound_edge_det (register + rising-edge pulse, async reset) SHALL be instantiated three times; the FSM stays in sound_event_ctrl.

Verification (bench parameters: DUR_BOUNCE=8, DUR_BRICK=12, DUR_LOSE=20, GAP=4)
REQ-031 Single bounce: ev_bounce high at edge 10, held 50 cycles -> Sound_EN1 high edges 12..19 only, busy high 12..23, one event only.
REQ-032 Priority: ev_bounce and ev_brick rise same cycle 10 -> Sound_EN2 12..23, all low 24..28, Sound_EN1 29..36.
REQ-033 Preemption: ev_bounce at 10, ev_lose at 14 -> Sound_EN1 12..15, Sound_EN3 16..35, no Sound_EN1 afterwards.
REQ-034 Merge: three ev_brick pulses during one Sound_EN2 window -> exactly one further Sound_EN2 window of 12 cycles after GAP+1.
REQ-035 Reset: rst asserted at cycle 15 during Sound_EN3 -> Sound_EN3 and busy low same cycle (asynchronous), pending 000; ev_lose held high through release -> new Sound_EN3 window 2 cycles after release.
